// File: rtl/cm_pkg.sv
// Shared definitions for the image-parameter constant bank: the well-known
// addresses, their power-up values and the bank's two-state lifecycle.
package cm_pkg;

  localparam int CM_ADDR_SRC_FIRST = 3;
  localparam int CM_ADDR_DST_FIRST = 4;
  localparam int CM_ADDR_SRC_LAST  = 5;
  localparam int CM_ADDR_SRC_WIDTH = 6;

  localparam int CM_DEF_SRC_FIRST = 0;
  localparam int CM_DEF_DST_FIRST = 10000;
  localparam int CM_DEF_SRC_LAST  = 8259;
  localparam int CM_DEF_SRC_WIDTH = 118;

  typedef enum logic {CM_INIT, CM_RUN} cm_state_t;

  // Power-up contents; callers truncate the result to their data width.
  function automatic logic [31:0] cm_default(input int idx);
    case (idx)
      CM_ADDR_SRC_FIRST: return 32'(CM_DEF_SRC_FIRST);
      CM_ADDR_DST_FIRST: return 32'(CM_DEF_DST_FIRST);
      CM_ADDR_SRC_LAST:  return 32'(CM_DEF_SRC_LAST);
      CM_ADDR_SRC_WIDTH: return 32'(CM_DEF_SRC_WIDTH);
      default:           return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/cm_rd_port.sv
// One registered read port of the constant bank, with write-first bypass
// when the same-cycle write targets the address being read.
module cm_rd_port #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem [2**ADDR_W],
  input  logic              wr_we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (wr_we && (wr_addr == rd_addr)) rd_data <= wr_data;
        else                               rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/cm_bank.sv
// Image-parameter constant bank: self-loads defaults after reset, then serves
// NUM_RD registered read ports and one write port. Optional write lock: CM_LOCK_EN.
//
//   state   | meaning
//   CM_INIT | loading default(idx) into mem[idx], one entry per cycle
//   CM_RUN  | defaults loaded, reads and writes accepted
module cm_bank
  import cm_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     ready,
`ifdef CM_LOCK_EN
  input  logic                     lock_set,
  output logic                     locked,
`endif
  output logic                     wr_err
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  cm_state_t         state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              wr_blocked;
  logic              init_we;
  logic              run_we;

`ifdef CM_LOCK_EN
  assign wr_blocked = locked;
`else
  assign wr_blocked = 1'b0;
`endif

  assign init_we = !reset && (state_q == CM_INIT);
  assign run_we  = !reset && (state_q == CM_RUN) && wr_en && !wr_blocked;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CM_INIT;
      idx_q   <= '0;
      ready   <= 1'b0;
      wr_err  <= 1'b0;
`ifdef CM_LOCK_EN
      locked  <= 1'b0;
`endif
    end else begin
      wr_err <= wr_en && ((state_q == CM_INIT) || wr_blocked);
      if (state_q == CM_INIT) begin
        idx_q <= idx_q + 1'b1;
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_q <= CM_RUN;
          ready   <= 1'b1;
        end
      end else begin
`ifdef CM_LOCK_EN
        if (lock_set) locked <= 1'b1;
`endif
      end
    end
  end

  // Storage has no reset of its own: the INIT sweep rewrites every entry.
  always_ff @(posedge clock) begin
    if (init_we)     mem[idx_q]   <= DATA_W'(cm_default(int'(idx_q)));
    else if (run_we) mem[wr_addr] <= wr_data;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    cm_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd_port (
      .clock    (clock),
      .reset    (reset),
      .rd_en    (rd_en[i] && (state_q == CM_RUN)),
      .rd_addr  (rd_addr[i*ADDR_W +: ADDR_W]),
      .mem      (mem),
      .wr_we    (run_we),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[i*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[i])
    );
  end

endmodule

// File: tb/tb_cm_bank.sv
// Scoreboard bench for cm_bank: directed scenarios then randomized traffic
// against an array-based model of the bank's contents and lifecycle.
module tb_cm_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [19:0] wr_data;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic [39:0] rd_data;
  logic [1:0]  rd_valid;
  logic        ready;
  logic        wr_err;
`ifdef CM_LOCK_EN
  logic        lock_set;
  logic        locked;
`endif

  always #5 clock = ~clock;

  cm_bank dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .ready    (ready),
`ifdef CM_LOCK_EN
    .lock_set (lock_set),
    .locked   (locked),
`endif
    .wr_err   (wr_err)
  );

  int unsigned m_mem [8];
  int          m_init;
  bit          m_locked;
  bit          m_wr_err;
  int unsigned exp_q [2][$];
  int unsigned last_data [2];
  bit          mon_on = 1'b0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  function automatic void check(input string name, input int unsigned act, input int unsigned exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic void load_defaults();
    foreach (m_mem[i]) m_mem[i] = 0;
    m_mem[4] = 10000;
    m_mem[5] = 8259;
    m_mem[6] = 118;
  endfunction

  // Output monitor: each expected read must appear exactly one edge after issue.
  always @(negedge clock) begin
    if (mon_on) begin
      for (int i = 0; i < 2; i++) begin
        if (exp_q[i].size() > 0) begin
          int unsigned e;
          e = exp_q[i].pop_front();
          last_data[i] = e;
          check($sformatf("rd_valid%0d_pulse", i), rd_valid[i], 1);
          check($sformatf("rd_data%0d", i), rd_data[i*20 +: 20], e);
        end else begin
          check($sformatf("rd_valid%0d_idle", i), rd_valid[i], 0);
          check($sformatf("rd_data%0d_hold", i), rd_data[i*20 +: 20], last_data[i]);
        end
      end
    end
  end

  task automatic step(input bit r, input bit we, input int unsigned wa, input int unsigned wd,
                      input bit [1:0] re, input int unsigned ra0, input int unsigned ra1,
                      input bit ls);
    bit [2:0] a0, a1, aw;
    a0 = ra0[2:0];
    a1 = ra1[2:0];
    aw = wa[2:0];
    reset   = r;
    wr_en   = we;
    wr_addr = aw;
    wr_data = wd[19:0];
    rd_en   = re;
    rd_addr = {a1, a0};
`ifdef CM_LOCK_EN
    lock_set = ls;
`endif
    if (r) begin
      load_defaults();
      m_init   = 0;
      m_wr_err = 0;
      m_locked = 0;
      last_data[0] = 0;
      last_data[1] = 0;
    end else if (m_init < 8) begin
      m_init++;
      m_wr_err = we;
    end else begin
      m_wr_err = we && m_locked;
      if (we && !m_locked) m_mem[aw] = wd & 32'hFFFFF;
      if (re[0]) exp_q[0].push_back(m_mem[a0]);
      if (re[1]) exp_q[1].push_back(m_mem[a1]);
`ifdef CM_LOCK_EN
      if (ls) m_locked = 1;
`else
      if (ls) m_locked = 0;
`endif
    end
    @(posedge clock);
    #1;
    mon_on = 1'b1;
    check("ready", ready, (m_init == 8) ? 1 : 0);
    check("wr_err", wr_err, m_wr_err);
`ifdef CM_LOCK_EN
    check("locked", locked, m_locked);
`endif
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
`ifdef CM_LOCK_EN
    lock_set = 1'b0;
`endif
    @(negedge clock); #1;

    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    idle(8);
    step(0, 0, 0, 0, 2'b01, 6, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 2'b11, 3, 5, 0);
    idle(1);
    step(0, 1, 4, 20000, 2'b10, 0, 4, 0);
    step(0, 0, 0, 0, 2'b01, 4, 0, 0);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    step(0, 1, 6, 55, 2'b11, 6, 6, 0);
    idle(7);
    step(0, 0, 0, 0, 2'b01, 6, 0, 0);
    step(0, 1, 4, 20000, 2'b00, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    idle(8);
    step(0, 0, 0, 0, 2'b11, 4, 4, 0);
    step(0, 1, 2, 777, 2'b00, 0, 0, 1);
    step(0, 1, 6, 99, 2'b00, 0, 0, 0);
    step(0, 0, 0, 0, 2'b11, 6, 2, 0);
    step(1, 0, 0, 0, 2'b00, 0, 0, 0);
    idle(8);

    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(79) == 0), ($urandom_range(2) == 0), $urandom_range(7),
           $urandom, 2'($urandom_range(3)), $urandom_range(7), $urandom_range(7),
           ($urandom_range(149) == 0));
    end
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
